// File: rtl/mac_tcdm_responder_pkg.sv
// Shared TCDM request type and word-interleaved address helpers for the
// multi-bank responder.
package mac_tcdm_responder_pkg;

  localparam int unsigned TCDM_BE_W = 4;
  localparam int unsigned TCDM_AW   = 32;
  localparam int unsigned TCDM_DW   = 32;

  typedef struct packed {
    logic [TCDM_AW-1:0]   add;
    logic                 wen;
    logic [TCDM_BE_W-1:0] be;
    logic [TCDM_DW-1:0]   data;
  } tcdm_req_t;

  // Word-interleaved map: low word bits pick the bank, the rest pick the row.
  // nb and words are powers of two, so these reduce to bit slices.
  function automatic int unsigned bank_of(logic [TCDM_AW-1:0] add, int unsigned nb);
    return (add >> 2) % nb;
  endfunction

  function automatic int unsigned row_of(logic [TCDM_AW-1:0] add, int unsigned nb,
                                         int unsigned words);
    return ((add >> 2) / nb) % (words / nb);
  endfunction

endpackage

// File: rtl/mac_tcdm_bank.sv
// One TCDM bank: round-robin arbiter over all ports, byte-enabled flop
// storage, and a read-data register loaded on every grant.
module mac_tcdm_bank
  import mac_tcdm_responder_pkg::*;
#(
  parameter int unsigned NP    = 4,
  parameter int unsigned NB    = 4,
  parameter int unsigned WORDS = 1024,
  localparam int unsigned ROWS = WORDS / NB,
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned PW   = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic      [NP-1:0]     req_i,
  input  tcdm_req_t [NP-1:0]     preq_i,
  output logic      [NP-1:0]     gnt_o,
  output logic                   flag_o,
  output logic      [TCDM_DW-1:0] rdata_o
);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win, idx;
  logic               any;
  logic               acc;
  tcdm_req_t          wreq;
  logic [RW-1:0]      wrow;
  logic [TCDM_DW-1:0] rdata_q;
  logic [TCDM_DW-1:0] mem_q [ROWS];

  // First requester at or after the pointer, walking ports modulo NP.
  always_comb begin
    win = ptr_q;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < int'(NP); i++) begin
      idx = PW'((32'(ptr_q) + 32'(i)) % NP);
      if (!any && req_i[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (any) begin
      gnt_o[win] = 1'b1;
      ptr_d      = (32'(win) == NP - 1) ? '0 : win + PW'(1);
    end
  end

  assign flag_o  = (req_i & (req_i - NP'(1))) != '0;
  assign acc     = any && !clear_i;
  assign wreq    = preq_i[win];
  assign wrow    = RW'(row_of(wreq.add, NB, WORDS));
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      // Writes answer with zero data; reads see the row before this edge's write.
      if (acc) rdata_q <= wreq.wen ? mem_q[wrow] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc && !wreq.wen) begin
      for (int b = 0; b < int'(TCDM_BE_W); b++) begin
        if (wreq.be[b]) mem_q[wrow][8*b +: 8] <= wreq.data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mac_tcdm_responder.sv
// Multi-port, multi-bank TCDM slave: bank decode, per-bank arbitration and
// one-cycle read/write responses per port.
module mac_tcdm_responder
  import mac_tcdm_responder_pkg::*;
#(
  parameter int unsigned NP    = 4,
  parameter int unsigned NB    = 4,
  parameter int unsigned WORDS = 1024,
  parameter int unsigned DW    = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic [NP-1:0]                  tcdm_req_i,
  output logic [NP-1:0]                  tcdm_gnt_o,
  input  logic [NP-1:0][TCDM_AW-1:0]     tcdm_add_i,
  input  logic [NP-1:0]                  tcdm_wen_i,
  input  logic [NP-1:0][TCDM_BE_W-1:0]   tcdm_be_i,
  input  logic [NP-1:0][DW-1:0]          tcdm_data_i,
  output logic [NP-1:0][DW-1:0]          tcdm_r_data_o,
  output logic [NP-1:0]                  tcdm_r_valid_o,
  output logic [NB-1:0]                  flags_o
);

  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  tcdm_req_t [NP-1:0]         preq;
  logic [NP-1:0][BW-1:0]      pbank;
  logic [NB-1:0][NP-1:0]      bank_req;
  logic [NB-1:0][NP-1:0]      bank_gnt;
  logic [NB-1:0][DW-1:0]      bank_rdata;
  logic [NP-1:0]              r_valid_q;
  logic [NP-1:0][BW-1:0]      bsel_q;
  logic [NP-1:0][DW-1:0]      hold_q;

  always_comb begin
    preq  = '0;
    pbank = '0;
    for (int p = 0; p < int'(NP); p++) begin
      preq[p].add  = tcdm_add_i[p];
      preq[p].wen  = tcdm_wen_i[p];
      preq[p].be   = tcdm_be_i[p];
      preq[p].data = tcdm_data_i[p];
      pbank[p]     = BW'(bank_of(tcdm_add_i[p], NB));
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar p = 0; p < NP; p++) begin : g_req
      assign bank_req[b][p] = tcdm_req_i[p] && (pbank[p] == BW'(b));
    end

    mac_tcdm_bank #(
      .NP    (NP),
      .NB    (NB),
      .WORDS (WORDS)
    ) i_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .req_i   (bank_req[b]),
      .preq_i  (preq),
      .gnt_o   (bank_gnt[b]),
      .flag_o  (flags_o[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    tcdm_gnt_o = '0;
    for (int b = 0; b < int'(NB); b++) tcdm_gnt_o |= bank_gnt[b];
  end

  // While valid, show the granting bank's data register; otherwise hold the
  // last value returned on this port.
  always_comb begin
    tcdm_r_data_o = '0;
    for (int p = 0; p < int'(NP); p++)
      tcdm_r_data_o[p] = r_valid_q[p] ? bank_rdata[bsel_q[p]] : hold_q[p];
  end

  assign tcdm_r_valid_o = r_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      bsel_q    <= '0;
      hold_q    <= '0;
    end else begin
      r_valid_q <= tcdm_gnt_o;
      hold_q    <= tcdm_r_data_o;
      for (int p = 0; p < int'(NP); p++)
        if (tcdm_gnt_o[p]) bsel_q[p] <= pbank[p];
    end
  end

endmodule

// File: tb/tb_mac_tcdm_responder.sv
// Directed and randomized checks of the TCDM responder against a
// word-array memory model with per-bank round-robin pointers.
module tb_mac_tcdm_responder;

  localparam int NP = 4;
  localparam int NB = 4;
  localparam int WORDS = 1024;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [NP-1:0]        req = '0, wen = '0;
  logic [NP-1:0][31:0]  add = '0, wdata = '0;
  logic [NP-1:0][3:0]   be = '0;
  logic [NP-1:0]        gnt, rvalid;
  logic [NP-1:0][31:0]  rdata;
  logic [NB-1:0]        flags;

  int errors = 0, checks = 0;

  logic [31:0]   mdl_mem [WORDS];
  int            mdl_ptr [NB];
  logic [NP-1:0] mdl_rv;
  logic [31:0]   mdl_rd [NP];
  logic [NP-1:0] obs_gnt;
  logic [NB-1:0] obs_flags;

  always #5 clk = ~clk;

  mac_tcdm_responder #(.NP(NP), .NB(NB), .WORDS(WORDS), .DW(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (rdata),
    .tcdm_r_valid_o (rvalid),
    .flags_o        (flags)
  );

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic drive(int p, bit r, bit wn, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    req[p] = r; wen[p] = wn; add[p] = a; be[p] = b; wdata[p] = d;
  endtask

  task automatic idle();
    req = '0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) mdl_ptr[b] = 0;
    for (int p = 0; p < NP; p++) mdl_rd[p] = '0;
    mdl_rv = '0;
  endtask

  // Inputs are set after a rising edge; check combinational outputs at the
  // falling edge, then responses just after the next rising edge.
  task automatic step();
    logic [NP-1:0]       eg;
    logic [NB-1:0]       ef;
    logic [NP-1:0][31:0] erd;
    @(negedge clk);
    eg = '0; ef = '0;
    for (int b = 0; b < NB; b++) begin
      int cnt;
      bit found;
      cnt = 0; found = 0;
      for (int p = 0; p < NP; p++)
        if (req[p] && (word_of(add[p]) % NB) == b) cnt++;
      ef[b] = (cnt >= 2);
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (mdl_ptr[b] + k) % NP;
        if (!found && !clear && req[p] && (word_of(add[p]) % NB) == b) begin
          found = 1; eg[p] = 1'b1; mdl_ptr[b] = (p + 1) % NP;
        end
      end
    end
    if (clear) for (int b = 0; b < NB; b++) mdl_ptr[b] = 0;
    obs_gnt = gnt; obs_flags = flags;
    chk("gnt", gnt, eg);
    chk("flags", flags, ef);
    for (int p = 0; p < NP; p++)
      if (eg[p]) mdl_rd[p] = wen[p] ? mdl_mem[word_of(add[p])] : 32'h0;
    for (int p = 0; p < NP; p++)
      if (eg[p] && !wen[p])
        for (int i = 0; i < 4; i++)
          if (be[p][i]) mdl_mem[word_of(add[p])][8*i +: 8] = wdata[p][8*i +: 8];
    mdl_rv = eg;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) erd[p] = mdl_rd[p];
    chk("r_valid", rvalid, mdl_rv);
    chk("r_data", rdata, erd);
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_gnt", gnt, '0);
    chk("reset_rvalid", rvalid, '0);
    chk("reset_rdata", rdata, '0);
    chk("reset_flags", flags, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill words 0..63 so later reads are defined.
    for (int i = 0; i < 64; i += 4) begin
      for (int p = 0; p < NP; p++) drive(p, 1, 0, 32'((i + p) * 4), 4'hF, $urandom);
      step();
    end

    idle(); drive(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF); step();
    chk("tp1_wgnt", obs_gnt[0], 1);
    drive(0, 1, 1, 32'h10, 4'hF, 32'h0); step();
    chk("tp1_rgnt", obs_gnt[0], 1);
    chk("tp1_rvalid", rvalid[0], 1);
    chk("tp1_rdata", rdata[0], 32'hDEADBEEF);

    drive(0, 1, 0, 32'h10, 4'h4, 32'h00AA0000); step();
    drive(0, 1, 1, 32'h10, 4'hF, 32'h0); step();
    chk("tp2_rdata", rdata[0], 32'hDEAABEEF);

    for (int p = 0; p < NP; p++) drive(p, 1, 1, 32'(p * 4), 4'hF, 32'h0);
    step();
    chk("tp3_gnt", obs_gnt, 4'hF);
    chk("tp3_flags", obs_flags, 4'h0);
    chk("tp3_rvalid", rvalid, 4'hF);

    idle(); clear = 1'b1;
    drive(0, 1, 1, 32'h0, 4'hF, 0); drive(1, 1, 1, 32'h10, 4'hF, 0); step();
    chk("clr_gnt", obs_gnt, 4'h0);
    chk("clr_rvalid", rvalid, 4'h0);
    clear = 1'b0;

    idle();
    drive(0, 1, 1, 32'h00, 4'hF, 0); drive(1, 1, 1, 32'h10, 4'hF, 0);
    drive(2, 1, 1, 32'h20, 4'hF, 0); step();
    chk("tp4_gnt0", obs_gnt, 4'b0001);
    chk("tp4_flag0", obs_flags[0], 1);
    chk("tp4_rv0", rvalid, 4'b0001);
    req[0] = 1'b0; step();
    chk("tp4_gnt1", obs_gnt, 4'b0010);
    chk("tp4_flag1", obs_flags[0], 1);
    chk("tp4_rv1", rvalid, 4'b0010);
    req[1] = 1'b0; step();
    chk("tp4_gnt2", obs_gnt, 4'b0100);
    chk("tp4_flag2", obs_flags[0], 0);
    chk("tp4_rv2", rvalid, 4'b0100);

    idle(); drive(0, 1, 0, 32'h0, 4'hF, 32'h12345678); step();
    idle(); drive(1, 1, 1, 32'h1000, 4'hF, 32'h0); step();
    chk("tp5_wrap", rdata[1], 32'h12345678);

    idle(); drive(0, 1, 1, 32'h0, 4'hF, 0); step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rvalid", rvalid, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_gnt", gnt, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 1, 1, 32'h0, 4'hF, 0); drive(1, 1, 1, 32'h10, 4'hF, 0); step();
    chk("rst_rr", obs_gnt, 4'b0001);

    // Random traffic over words 0..63 with aliasing high bits and junk low bits.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        logic [31:0] a;
        a = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3) | (($urandom & 32'h3) << 12);
        drive(p, ($urandom % 4) != 0, $urandom % 2, a, 4'($urandom), $urandom);
      end
      clear = (($urandom % 25) == 0);
      step();
    end
    clear = 1'b0; idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
